// File: rtl/energy_sample_accumulator.sv
// Multi-channel windowed sample accumulator with peak tracking, sticky
// per-channel threshold alarms and a round-robin valid/ready result stream.
// Each channel averages 2^WIN_LOG2 samples; finished windows wait in a
// one-deep per-channel slot until the output register picks them up.
module energy_sample_accumulator #(
    parameter  int DATA_W   = 8,
    parameter  int CHANNELS = 4,
    parameter  int WIN_LOG2 = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W-1:0]   thresh,
    input  logic                alarm_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [DATA_W-1:0]   out_avg,
    output logic [DATA_W-1:0]   out_peak,
    output logic [CHANNELS-1:0] alarm,
    output logic                overrun
);

    localparam int                  ACC_W    = DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    // Truncating window average: drop the WIN_LOG2 fractional bits.
    function automatic logic [DATA_W-1:0] win_avg(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1:WIN_LOG2];
    endfunction

    // Unsigned maximum used for peak tracking.
    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Round-robin successor of a channel index, wrapping at CHANNELS.
    function automatic logic [CH_W-1:0] next_rr(input logic [CH_W-1:0] ch);
        if (ch == CH_W'(CHANNELS - 1)) begin
            return '0;
        end
        return ch + 1'b1;
    endfunction

    // Per-channel accumulation state
    logic [ACC_W-1:0]    acc       [CHANNELS];
    logic [WIN_LOG2-1:0] cnt       [CHANNELS];
    logic [DATA_W-1:0]   peak      [CHANNELS];

    // Per-channel finished-window slots
    logic [DATA_W-1:0]   slot_avg  [CHANNELS];
    logic [DATA_W-1:0]   slot_peak [CHANNELS];
    logic [CHANNELS-1:0] pending;

    logic [CH_W-1:0]     rr_ptr;

    // Stage 0: sample acceptance and window arithmetic (combinational)
    logic                in_range;
    logic                vld_p0;
    logic [CH_W-1:0]     ch_p0;
    logic [ACC_W-1:0]    sum_p0;
    logic [DATA_W-1:0]   peak_p0;
    logic [DATA_W-1:0]   avg_p0;
    logic                done_p0;

    // Output arbitration
    logic                sel_found;
    logic [CH_W-1:0]     sel_ch;
    logic                load;
    int                  arb_idx;

    // Qualify the incoming sample and compute the updated sum/peak for its channel.
    always_comb begin
        in_range = 32'(in_ch) < 32'(CHANNELS);
        vld_p0   = ena && in_valid && in_range;
        // Out-of-range channels are steered to index 0 only to keep reads in
        // bounds; vld_p0 is low for them so nothing is written.
        ch_p0    = in_range ? in_ch : '0;
        sum_p0   = acc[ch_p0] + ACC_W'(in_data);
        peak_p0  = max_u(peak[ch_p0], in_data);
        avg_p0   = win_avg(sum_p0);
        done_p0  = vld_p0 && (cnt[ch_p0] == CNT_LAST);
    end

    // Pick the first pending slot at or above rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        arb_idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            arb_idx = (int'(rr_ptr) + i) % CHANNELS;
            if (!sel_found && pending[arb_idx]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(arb_idx);
            end
        end
        load = (!out_valid || out_ready) && sel_found;
    end

    // Accumulate accepted samples; restart the window after its last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]  <= '0;
                cnt[c]  <= '0;
                peak[c] <= '0;
            end
        end else if (vld_p0) begin
            if (done_p0) begin
                acc[ch_p0]  <= '0;
                cnt[ch_p0]  <= '0;
                peak[ch_p0] <= '0;
            end else begin
                acc[ch_p0]  <= sum_p0;
                cnt[ch_p0]  <= cnt[ch_p0] + 1'b1;
                peak[ch_p0] <= peak_p0;
            end
        end
    end

    // Capture finished windows into slots; a new result beats a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                slot_avg[c]  <= '0;
                slot_peak[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (done_p0 && (ch_p0 == CH_W'(c))) begin
                    slot_avg[c]  <= avg_p0;
                    slot_peak[c] <= peak_p0;
                    pending[c]   <= 1'b1;
                end else if (load && (sel_ch == CH_W'(c))) begin
                    pending[c]   <= 1'b0;
                end
            end
        end
    end

    // Sticky alarm and overrun flags; a set in the same cycle as alarm_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm   <= '0;
            overrun <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (done_p0 && (ch_p0 == CH_W'(c)) && (avg_p0 > thresh)) begin
                    alarm[c] <= 1'b1;
                end else if (alarm_clr) begin
                    alarm[c] <= 1'b0;
                end
            end
            if (done_p0 && pending[ch_p0] && !(load && (sel_ch == ch_p0))) begin
                overrun <= 1'b1;
            end else if (alarm_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Output register: load the arbitrated slot when free, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_avg   <= '0;
            out_peak  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ch    <= sel_ch;
            out_avg   <= slot_avg[sel_ch];
            out_peak  <= slot_peak[sel_ch];
            rr_ptr    <= next_rr(sel_ch);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_energy_sample_accumulator.sv
// Scoreboard bench for energy_sample_accumulator: directed scenarios plus a
// randomized phase, all checked against a window-level reference model.
module tb_energy_sample_accumulator;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 4;
    localparam int WIN_LOG2 = 2;
    localparam int CH_W     = 2;
    localparam int WIN      = 1 << WIN_LOG2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                ena = 1'b1;
    logic                in_valid = 1'b0;
    logic [CH_W-1:0]     in_ch = '0;
    logic [DATA_W-1:0]   in_data = '0;
    logic [DATA_W-1:0]   thresh = 8'd255;
    logic                alarm_clr = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [CH_W-1:0]     out_ch;
    logic [DATA_W-1:0]   out_avg;
    logic [DATA_W-1:0]   out_peak;
    logic [CHANNELS-1:0] alarm;
    logic                overrun;

    // Second instance with three channels so an unreachable index can be driven
    logic                in_valid3 = 1'b0;
    logic [1:0]          in_ch3 = '0;
    logic                out_ready3 = 1'b1;
    logic                out_valid3;
    logic [1:0]          out_ch3;
    logic [DATA_W-1:0]   out_avg3;
    logic [DATA_W-1:0]   out_peak3;
    logic [2:0]          alarm3;
    logic                overrun3;

    always #5 clk = ~clk;

    energy_sample_accumulator #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .WIN_LOG2(WIN_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ch(in_ch),
        .in_data(in_data), .thresh(thresh), .alarm_clr(alarm_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_avg(out_avg), .out_peak(out_peak), .alarm(alarm), .overrun(overrun)
    );

    energy_sample_accumulator #(.DATA_W(DATA_W), .CHANNELS(3), .WIN_LOG2(WIN_LOG2)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid3), .in_ch(in_ch3),
        .in_data(in_data), .thresh(thresh), .alarm_clr(alarm_clr),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3),
        .out_avg(out_avg3), .out_peak(out_peak3), .alarm(alarm3), .overrun(overrun3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-channel partial window and expected result queues
    int          m_sum [CHANNELS];
    int          m_max [CHANNELS];
    int          m_n   [CHANNELS];
    logic [15:0] exp_q [CHANNELS][$];
    int          exp_order[$];
    logic [CHANNELS-1:0] m_alarm;
    bit          throttle = 1'b0;

    logic [15:0] mon_e;
    int          mon_o;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_total();
        int t = 0;
        for (int c = 0; c < CHANNELS; c++) t += exp_q[c].size();
        return t;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_sum[c] = 0;
            m_max[c] = 0;
            m_n[c]   = 0;
            exp_q[c].delete();
        end
        exp_order.delete();
        m_alarm = '0;
    endtask

    task automatic model_sample(input int ch, input int d);
        int avg;
        m_sum[ch] += d;
        if (d > m_max[ch]) m_max[ch] = d;
        m_n[ch]++;
        if (m_n[ch] == WIN) begin
            avg = m_sum[ch] / WIN;
            exp_q[ch].push_back({8'(avg), 8'(m_max[ch])});
            if (avg > int'(thresh)) m_alarm[ch] = 1'b1;
            m_sum[ch] = 0;
            m_max[ch] = 0;
            m_n[ch]   = 0;
        end
    endtask

    // Present one sample for the next rising edge, then step past it.
    task automatic drive(input bit v, input int ch, input int d);
        in_valid = v;
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(d);
        if (throttle && ena && v && m_n[ch] == WIN - 1 && exp_q[ch].size() != 0)
            in_valid = 1'b0;
        if (ena && in_valid) model_sample(ch, d);
        @(posedge clk); #1;
    endtask

    task automatic window(input int ch, input int d);
        repeat (WIN) drive(1'b1, ch, d);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clr();
        alarm_clr = 1'b1;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_total() != 0 || out_valid) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_complete", exp_total() + int'(out_valid), 0);
    endtask

    task automatic drive3(input int ch, input int d);
        in_valid3 = 1'b1;
        in_ch3    = 2'(ch);
        in_data   = DATA_W'(d);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
    endtask

    // Monitor: every accepted output is popped from its channel's queue and compared
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q[out_ch].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: ch=%0d avg=%0d peak=%0d, expected none",
                         out_ch, out_avg, out_peak);
            end else begin
                mon_e = exp_q[out_ch].pop_front();
                check("out_avg", int'(out_avg), int'(mon_e[15:8]));
                check("out_peak", int'(out_peak), int'(mon_e[7:0]));
            end
            if (exp_order.size() != 0) begin
                mon_o = exp_order.pop_front();
                check("rr_order", int'(out_ch), mon_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // 1. Reset
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_avg", int'(out_avg), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(5);
        check("idle_no_valid", int'(out_valid), 0);

        // 2. Basic average
        thresh = 8'd255;
        drive(1'b1, 0, 10); drive(1'b1, 0, 20); drive(1'b1, 0, 30); drive(1'b1, 0, 41);
        in_valid = 1'b0;
        check("latency_not_yet", int'(out_valid), 0);
        @(posedge clk); #1;
        check("latency_valid", int'(out_valid), 1);
        check("basic_ch", int'(out_ch), 0);
        check("basic_avg", int'(out_avg), 25);
        check("basic_peak", int'(out_peak), 41);
        check("basic_alarm", int'(alarm), 0);
        drain();

        // 3. Alarm
        thresh = 8'd100;
        window(1, 200); drain();
        check("alarm_ch1", int'(alarm), 2);
        window(2, 100); drain();
        check("alarm_equal_thresh", int'(alarm), 2);
        pulse_clr();
        check("alarm_clr", int'(alarm), 0);
        window(0, 150); drain();
        check("alarm_ch0", int'(alarm), 1);
        drive(1'b1, 1, 200); drive(1'b1, 1, 200); drive(1'b1, 1, 200);
        alarm_clr = 1'b1;
        drive(1'b1, 1, 200);
        alarm_clr = 1'b0;
        in_valid = 1'b0;
        check("alarm_set_beats_clr", int'(alarm), 2);
        drain();
        pulse_clr();

        // 4. Backpressure / overrun
        thresh = 8'd255;
        out_ready = 1'b0;
        window(2, 5); idle(2);
        check("bp_valid", int'(out_valid), 1);
        check("bp_avg_5", int'(out_avg), 5);
        window(2, 6);
        check("bp_hold_5", int'(out_avg), 5);
        check("bp_no_overrun", int'(overrun), 0);
        window(2, 7); idle(1);
        check("bp_overrun", int'(overrun), 1);
        check("bp_hold_5_again", int'(out_avg), 5);
        check("bp_hold_ch", int'(out_ch), 2);
        // the 6 was overwritten in the slot by the 7
        exp_q[2].delete(1);
        drain();
        check("overrun_sticky", int'(overrun), 1);
        pulse_clr();
        check("overrun_cleared", int'(overrun), 0);

        // 5. Round-robin
        out_ready = 1'b0;
        window(2, 9); idle(2);
        window(3, 30); window(1, 10); window(0, 20);
        exp_order.push_back(2); exp_order.push_back(3);
        exp_order.push_back(0); exp_order.push_back(1);
        drain();
        check("rr_order_done", exp_order.size(), 0);

        // 6. Gating (pending ch1 result drains while ena is low)
        out_ready = 1'b0;
        window(1, 60); idle(1);
        drive(1'b1, 0, 10); drive(1'b1, 0, 20);
        ena = 1'b0;
        out_ready = 1'b1;
        repeat (5) drive(1'b1, 0, 250);
        ena = 1'b1;
        drive(1'b1, 0, 30); drive(1'b1, 0, 40);
        drain();

        // Asynchronous reset mid-cycle with live state, then a fresh window
        out_ready = 1'b0;
        thresh = 8'd100;
        window(3, 250); idle(2);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_ch", int'(out_ch), 3);
        check("pre_rst_alarm", int'(alarm), 8);
        drive(1'b1, 0, 200); drive(1'b1, 0, 200);
        in_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ch", int'(out_ch), 0);
        check("mid_rst_avg", int'(out_avg), 0);
        check("mid_rst_peak", int'(out_peak), 0);
        check("mid_rst_alarm", int'(alarm), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        thresh = 8'd255;
        idle(4);
        check("post_rst_idle", int'(out_valid), 0);
        window(0, 8);
        drain();

        // Randomized traffic with random backpressure and enable
        thresh = 8'($urandom_range(60, 200));
        pulse_clr();
        m_alarm = '0;
        throttle = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, CHANNELS - 1)),
                  int'($urandom_range(0, 255)));
        end
        ena = 1'b1;
        throttle = 1'b0;
        drain();
        check("rand_alarm", int'(alarm), int'(m_alarm));
        check("rand_no_overrun", int'(overrun), 0);

        // Three-channel build: channel index 3 must be ignored
        drive3(0, 8); drive3(0, 8);
        repeat (4) drive3(3, 200);
        idle(2);
        check("ch3_ignored", int'(out_valid3), 0);
        drive3(0, 8); drive3(0, 8);
        begin
            int k = 0;
            while (!out_valid3 && k < 4) begin @(posedge clk); #1; k++; end
        end
        check("c3_valid", int'(out_valid3), 1);
        check("c3_ch", int'(out_ch3), 0);
        check("c3_avg", int'(out_avg3), 8);
        check("c3_peak", int'(out_peak3), 8);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
